// File: rtl/dma_pkg.sv
// Shared definitions for the sprite-attribute (OAM) DMA controller.
//   dma_state_t   : controller FSM state encoding (also exported on the debug port)
//   DMA_REG_ADDR  : CPU address of the DMA source register
//   OAM_XFER_LEN  : bytes copied per transfer (size of OAM)
//   HRAM_IO_BASE  : accesses at or above this address never touch the system bus
//   OAM_BASE      : CPU-visible OAM base, kept for trace/decode tooling
//   mirror_src()  : folds echo-RAM source pages (E0..FF) onto C0..DF
package dma_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_SETUP = 2'd1,
    DMA_RD    = 2'd2,
    DMA_WR    = 2'd3
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_XFER_LEN = 160;
  localparam logic [15:0] HRAM_IO_BASE = 16'hFF00;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;

  // Pages E0..FF alias the work RAM at C0..DF; clearing bit 5 maps them back.
  function automatic logic [7:0] mirror_src(input logic [7:0] raw);
    return (raw >= 8'hE0) ? (raw & 8'hDF) : raw;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Address generator for the OAM DMA.
// Holds the effective source page and the byte index of the transfer.
//   cpu_clk, rst : clock, asynchronous active-high reset
//   load_src     : capture a new source page from src_raw (mirror mask applied)
//   src_raw      : raw value written to the source register
//   clr_idx      : restart the byte index at 0 (has priority over inc_idx)
//   inc_idx      : advance the byte index; saturates at the last byte
//   dma_addr     : bus read address {src_hi, idx}
//   oam_addr     : OAM byte index (same as idx)
//   last         : idx is the final byte of the transfer
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int XFER_LEN = OAM_XFER_LEN
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        load_src,
  input  logic [7:0]  src_raw,
  input  logic        clr_idx,
  input  logic        inc_idx,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_addr,
  output logic        last
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  logic [7:0] src_hi;
  logic [7:0] idx;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      src_hi <= 8'h00;
      idx    <= 8'h00;
    end else begin
      if (load_src) begin
        src_hi <= mirror_src(src_raw);
      end
      if (clr_idx) begin
        idx <= 8'h00;
      end else if (inc_idx && !last) begin
        // Saturating: idx never passes the last byte, so it cannot wrap.
        idx <= idx + 8'd1;
      end
    end
  end

  assign last     = (idx == LAST_IDX);
  assign dma_addr = {src_hi, idx};
  assign oam_addr = idx;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-attribute DMA controller.
// A CPU write to the source register copies XFER_LEN bytes from page src_hi
// into OAM, one byte per RD/WR pair. While the copy runs the controller owns
// the system bus and stalls CPU accesses below HRAM_IO_BASE.
//
// Strobe semantics: cpu_we/cpu_re, dma_re and oam_we are single-cycle
// qualifiers with no back-pressure. A bus read issued with dma_re in cycle N
// returns its data on dma_rdata in cycle N+1; oam_we in cycle N+1 writes that
// data. dma_done is high for exactly one cycle, coincident with the final
// oam_we, unless a source-register write in that same cycle restarts the copy.
//
// Ports:
//   cpu_clk, rst          : clock, asynchronous active-high reset
//   cpu_addr/wdata/we/re  : CPU memory port
//   cpu_rdata             : source register readback, 8'h00 when not addressed
//   cpu_reg_hit           : CPU access targets the source register
//   cpu_stall             : CPU access below HRAM_IO_BASE during a copy
//   dma_active            : copy in progress (RD/WR), OAM busy for the PPU
//   dma_addr, dma_re      : system bus read port
//   dma_rdata             : system bus read data (one cycle after dma_re)
//   oam_addr/wdata/we     : OAM write port
//   dma_done              : final byte written
//   dbg_state             : FSM state, for debug/trace
module oam_dma_ctrl
  import dma_pkg::*;
#(
  parameter int          XFER_LEN = OAM_XFER_LEN,
  parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_reg_hit,
  output logic        cpu_stall,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_re,
  input  logic [7:0]  dma_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_done,
  output dma_state_t  dbg_state
);

  dma_state_t state;
  logic [7:0] src_reg;
  logic       reg_wr;
  logic       last;
  logic       clr_idx;
  logic       inc_idx;

  // A simultaneous read and write counts as a write.
  assign reg_wr      = cpu_we && (cpu_addr == REG_ADDR);
  assign cpu_reg_hit = (cpu_addr == REG_ADDR) && (cpu_re || cpu_we);
  assign cpu_rdata   = cpu_reg_hit ? src_reg : 8'h00;
  assign cpu_stall   = dma_active && (cpu_re || cpu_we) && (cpu_addr < HRAM_IO_BASE);

  // A write to the source register in the final WR cycle restarts the copy
  // and swallows the completion pulse of the one being replaced.
  assign dma_done  = (state == DMA_WR) && last && !reg_wr;

  // Read data only exists in the cycle after dma_re, so it is forwarded
  // straight through in the WR cycle rather than registered.
  assign oam_wdata = oam_we ? dma_rdata : 8'h00;

  assign clr_idx   = reg_wr || (state == DMA_SETUP);
  assign inc_idx   = (state == DMA_WR) && !reg_wr;
  assign dbg_state = state;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      src_reg <= 8'h00;
    end else if (reg_wr) begin
      src_reg <= cpu_wdata;
    end
  end

  // Strobes are registered together with the state they belong to, so each
  // one is high exactly while the FSM sits in RD (dma_re) or WR (oam_we).
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state      <= DMA_IDLE;
      dma_active <= 1'b0;
      dma_re     <= 1'b0;
      oam_we     <= 1'b0;
    end else if (reg_wr) begin
      // New source from any state: one dead SETUP cycle, then start at byte 0.
      state      <= DMA_SETUP;
      dma_active <= 1'b0;
      dma_re     <= 1'b0;
      oam_we     <= 1'b0;
    end else begin
      case (state)
        DMA_IDLE: begin
          state      <= DMA_IDLE;
          dma_active <= 1'b0;
          dma_re     <= 1'b0;
          oam_we     <= 1'b0;
        end
        DMA_SETUP: begin
          state      <= DMA_RD;
          dma_active <= 1'b1;
          dma_re     <= 1'b1;
          oam_we     <= 1'b0;
        end
        DMA_RD: begin
          state      <= DMA_WR;
          dma_active <= 1'b1;
          dma_re     <= 1'b0;
          oam_we     <= 1'b1;
        end
        DMA_WR: begin
          if (last) begin
            state      <= DMA_IDLE;
            dma_active <= 1'b0;
            dma_re     <= 1'b0;
            oam_we     <= 1'b0;
          end else begin
            state      <= DMA_RD;
            dma_active <= 1'b1;
            dma_re     <= 1'b1;
            oam_we     <= 1'b0;
          end
        end
        default: begin
          state      <= DMA_IDLE;
          dma_active <= 1'b0;
          dma_re     <= 1'b0;
          oam_we     <= 1'b0;
        end
      endcase
    end
  end

  dma_addr_gen #(
    .XFER_LEN (XFER_LEN)
  ) u_addr_gen (
    .cpu_clk  (cpu_clk),
    .rst      (rst),
    .load_src (reg_wr),
    .src_raw  (cpu_wdata),
    .clr_idx  (clr_idx),
    .inc_idx  (inc_idx),
    .dma_addr (dma_addr),
    .oam_addr (oam_addr),
    .last     (last)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl.
// A cycle-stamped trace of bus reads, OAM writes and done pulses is recorded
// and compared against a trace predicted from the list of source-register
// writes (cycle presented, value) using the transfer timing rules.
module tb_oam_dma_ctrl;
  import dma_pkg::*;

  localparam int XL = 160;

  // ---------------- clock / reset ----------------
  logic cpu_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic        cpu_reg_hit;
  logic        cpu_stall;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_re;
  logic [7:0]  dma_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_done;
  dma_state_t  dbg_state;

  oam_dma_ctrl dut (
    .cpu_clk     (cpu_clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_re      (cpu_re),
    .cpu_rdata   (cpu_rdata),
    .cpu_reg_hit (cpu_reg_hit),
    .cpu_stall   (cpu_stall),
    .dma_active  (dma_active),
    .dma_addr    (dma_addr),
    .dma_re      (dma_re),
    .dma_rdata   (dma_rdata),
    .oam_addr    (oam_addr),
    .oam_wdata   (oam_wdata),
    .oam_we      (oam_we),
    .dma_done    (dma_done),
    .dbg_state   (dbg_state)
  );

  // System bus: data = addr[7:0]^5A one cycle after a read, garbage otherwise.
  always @(posedge cpu_clk) begin
    if (dma_re) dma_rdata <= dma_addr[7:0] ^ 8'h5A;
    else        dma_rdata <= 8'($urandom);
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // Event word: {cycle[23:0], kind[3:0], payload[19:0]}; kind 1=read 2=oam write 3=done
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  wr_val_q[$];

  function automatic logic [47:0] ev(input int c, input logic [3:0] k, input logic [19:0] p);
    logic [23:0] c24;
    c24 = c[23:0];
    return {c24, k, p};
  endfunction

  always @(negedge cpu_clk) begin
    if (!rst) begin
      if (dma_re)   got_q.push_back(ev(cyc, 4'd1, {4'h0, dma_addr}));
      if (oam_we)   got_q.push_back(ev(cyc, 4'd2, {4'h0, oam_addr, oam_wdata}));
      if (dma_done) got_q.push_back(ev(cyc, 4'd3, 20'h0));
    end
  end

  // Reference: a write presented in cycle w reads byte i in cycle w+2+2i and
  // writes it to OAM in w+3+2i; done lands with the last write (w+1+2*XL).
  // A later write presented in cycle n cuts the trace: strobes up to and
  // including cycle n still happen, done only if it falls strictly before n.
  function automatic void build_model();
    int w, nxt;
    logic [7:0] src;
    exp_q.delete();
    for (int k = 0; k < wr_cyc_q.size(); k++) begin
      w   = wr_cyc_q[k];
      nxt = (k + 1 < wr_cyc_q.size()) ? wr_cyc_q[k+1] : 32'h7fffffff;
      src = (wr_val_q[k] >= 8'hE0) ? (wr_val_q[k] & 8'hDF) : wr_val_q[k];
      for (int i = 0; i < XL; i++) begin
        if (w + 2 + 2*i <= nxt) exp_q.push_back(ev(w + 2 + 2*i, 4'd1, {4'h0, src, 8'(i)}));
        if (w + 3 + 2*i <= nxt) exp_q.push_back(ev(w + 3 + 2*i, 4'd2, {4'h0, 8'(i), 8'(i) ^ 8'h5A}));
      end
      if (w + 1 + 2*XL < nxt) exp_q.push_back(ev(w + 1 + 2*XL, 4'd3, 20'h0));
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge cpu_clk);
      #1;
    end
  endtask

  // Called at posedge+1: presents the write for the current cycle.
  task automatic present_write(input logic [7:0] v);
    cpu_addr  = DMA_REG_ADDR;
    cpu_wdata = v;
    cpu_we    = 1'b1;
    cpu_re    = 1'b0;
    wr_cyc_q.push_back(cyc);
    wr_val_q.push_back(v);
    @(posedge cpu_clk);
    #1;
    idle_inputs();
  endtask

  task automatic start_scenario();
    wr_cyc_q.delete();
    wr_val_q.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(3);
    n_cmp++; if (dma_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b expected 0", dma_active); end
    n_cmp++; if (dma_re !== 1'b0) begin n_fail++; $display("FAIL reset_dma_re got %b expected 0", dma_re); end
    n_cmp++; if (oam_we !== 1'b0) begin n_fail++; $display("FAIL reset_oam_we got %b expected 0", oam_we); end
    n_cmp++; if (dma_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", dma_done); end
    n_cmp++; if (dma_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_dma_addr got %h expected 0000", dma_addr); end
    n_cmp++; if (oam_addr !== 8'h00) begin n_fail++; $display("FAIL reset_oam_addr got %h expected 00", oam_addr); end
    n_cmp++; if (oam_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_oam_wdata got %h expected 00", oam_wdata); end
    n_cmp++; if (dbg_state !== DMA_IDLE) begin n_fail++; $display("FAIL reset_state got %0d expected IDLE", dbg_state); end
    rst = 1'b0;
    step(2);
    cpu_re = 1'b1; cpu_addr = DMA_REG_ADDR; #1;
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_src_readback got %h expected 00", cpu_rdata); end
    n_cmp++; if (cpu_reg_hit !== 1'b1) begin n_fail++; $display("FAIL reg_hit_ff46 got %b expected 1", cpu_reg_hit); end
    cpu_addr = 16'hC123; #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL idle_no_stall got %b expected 0", cpu_stall); end
    n_cmp++; if (cpu_reg_hit !== 1'b0 || cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reg_miss got hit=%b rdata=%h expected 0/00", cpu_reg_hit, cpu_rdata); end
    idle_inputs();
    step(1);
  endtask

  task automatic test_transfer_and_stall();
    int w;
    int n_we;
    int n_done;
    int done_cyc;
    logic [15:0] a;
    start_scenario();
    step(1);
    present_write(8'hC0);
    w = wr_cyc_q[0];
    // SETUP cycle: bus not owned yet
    cpu_re = 1'b1; cpu_addr = 16'hC123; #1;
    n_cmp++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL setup_no_stall got %b expected 0", cpu_stall); end
    idle_inputs();
    step(1);
    n_cmp++; if (dma_re !== 1'b1 || dma_addr !== 16'hC000) begin n_fail++; $display("FAIL first_read got re=%b addr=%h expected 1/C000", dma_re, dma_addr); end
    step(3);
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       a = 16'hC123;
        1:       a = 16'hFF85;
        2:       a = DMA_REG_ADDR;
        3:       a = 16'hFEFF;
        4:       a = 16'hFF00;
        default: a = 16'($urandom_range(0, 65535));
      endcase
      cpu_re = 1'b1; cpu_addr = a; #1;
      n_cmp++; if (cpu_stall !== (a < 16'hFF00)) begin n_fail++; $display("FAIL stall_addr_%h got %b expected %b", a, cpu_stall, (a < 16'hFF00)); end
      n_cmp++; if (cpu_rdata !== ((a == DMA_REG_ADDR) ? 8'hC0 : 8'h00)) begin n_fail++; $display("FAIL rdata_addr_%h got %h", a, cpu_rdata); end
      idle_inputs();
      step(1);
    end
    cpu_we = 1'b1; cpu_addr = 16'hC123; cpu_wdata = 8'h11; #1;
    n_cmp++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL stall_on_write got %b expected 1", cpu_stall); end
    idle_inputs();
    wait_until(w + 2*XL + 10);
    build_model();
    got_q.sort(); exp_q.sort();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_event_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_event[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_we = 0; n_done = 0; done_cyc = -1;
    foreach (got_q[i]) begin
      if (got_q[i][23:20] == 4'd2) n_we++;
      if (got_q[i][23:20] == 4'd3) begin n_done++; done_cyc = int'(got_q[i][47:24]); end
    end
    n_cmp++; if (n_we != XL) begin n_fail++; $display("FAIL basic_oam_writes got %0d expected %0d", n_we, XL); end
    n_cmp++; if (n_done != 1 || done_cyc != w + 321) begin n_fail++; $display("FAIL basic_done got n=%0d at %0d expected 1 at %0d", n_done, done_cyc, w + 321); end
  endtask

  task automatic test_restart();
    int k;
    int n_done;
    start_scenario();
    step(1);
    present_write(8'hD0);
    k = 0;
    while (!(oam_we && oam_addr == 8'd40) && k < 400) begin step(1); k++; end
    n_cmp++; if (k >= 400) begin n_fail++; $display("FAIL restart_reach_40 got timeout expected oam_addr 40"); end
    present_write(8'hC1);
    n_cmp++; if (oam_we !== 1'b0 || dma_re !== 1'b0) begin n_fail++; $display("FAIL restart_setup_quiet got we=%b re=%b expected 0/0", oam_we, dma_re); end
    step(1);
    n_cmp++; if (dma_re !== 1'b1 || dma_addr !== 16'hC100) begin n_fail++; $display("FAIL restart_first_read got re=%b addr=%h expected 1/C100", dma_re, dma_addr); end
    wait_until(wr_cyc_q[1] + 2*XL + 10);
    build_model();
    got_q.sort(); exp_q.sort();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL restart_event_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_event[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_done = 0;
    foreach (got_q[i]) if (got_q[i][23:20] == 4'd3) n_done++;
    n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL restart_done_count got %0d expected 1", n_done); end
  endtask

  task automatic test_mirror();
    start_scenario();
    step(1);
    present_write(8'hF3);
    step(2);
    cpu_re = 1'b1; cpu_addr = DMA_REG_ADDR; #1;
    n_cmp++; if (cpu_rdata !== 8'hF3) begin n_fail++; $display("FAIL mirror_readback got %h expected F3", cpu_rdata); end
    n_cmp++; if (dma_addr !== 16'hD300) begin n_fail++; $display("FAIL mirror_first_addr got %h expected D300", dma_addr); end
    idle_inputs();
    wait_until(wr_cyc_q[0] + 2*XL + 10);
    build_model();
    got_q.sort(); exp_q.sort();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mirror_event_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mirror_event[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    start_scenario();
    step(1);
    present_write(8'h9A);
    k = 0;
    while (!(dma_re && dma_addr[7:0] == 8'd77) && k < 400) begin step(1); k++; end
    n_cmp++; if (k >= 400) begin n_fail++; $display("FAIL rstmid_reach_77 got timeout expected idx 77"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (dma_active !== 1'b0 || oam_we !== 1'b0 || dma_re !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes got act=%b we=%b re=%b expected 0/0/0", dma_active, oam_we, dma_re); end
    n_cmp++; if (dbg_state !== DMA_IDLE) begin n_fail++; $display("FAIL rstmid_state got %0d expected IDLE", dbg_state); end
    cpu_re = 1'b1; cpu_addr = DMA_REG_ADDR; #1;
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_src got %h expected 00", cpu_rdata); end
    idle_inputs();
    got_q.delete();
    step(2);
    rst = 1'b0;
    step(30);
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d events expected 0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    int w;
    int n_we;
    int n_done;
    start_scenario();
    step(1);
    present_write(8'h81);
    w = wr_cyc_q[0];
    wait_until(w + 1 + 2*XL);
    n_cmp++; if (oam_we !== 1'b1 || oam_addr !== 8'd159 || dma_done !== 1'b1) begin n_fail++; $display("FAIL b2b_last_cycle got we=%b addr=%0d done=%b expected 1/159/1", oam_we, oam_addr, dma_done); end
    // Restart in the done cycle itself.
    cpu_addr = DMA_REG_ADDR; cpu_wdata = 8'h42; cpu_we = 1'b1;
    wr_cyc_q.push_back(cyc);
    wr_val_q.push_back(8'h42);
    #1;
    n_cmp++; if (dma_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_suppressed got %b expected 0", dma_done); end
    @(posedge cpu_clk);
    #1;
    idle_inputs();
    wait_until(wr_cyc_q[1] + 2*XL + 10);
    build_model();
    got_q.sort(); exp_q.sort();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_event_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_event[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_we = 0; n_done = 0;
    foreach (got_q[i]) begin
      if (got_q[i][23:20] == 4'd2) n_we++;
      if (got_q[i][23:20] == 4'd3) n_done++;
    end
    n_cmp++; if (n_we != 2*XL || n_done != 1) begin n_fail++; $display("FAIL b2b_totals got we=%0d done=%0d expected %0d/1", n_we, n_done, 2*XL); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    start_scenario();
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(1, 400));
      if (i == 1) v = 8'($urandom_range(224, 255));
      else        v = 8'($urandom_range(0, 255));
      present_write(v);
    end
    wait_until(wr_cyc_q[3] + 2*XL + 10);
    build_model();
    got_q.sort(); exp_q.sort();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_event_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_event[%0d] got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_transfer_and_stall();
    test_restart();
    test_mirror();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
